instr_mem_loader: RTL

- Writer side of the instruction-memory interface. The datapath only ever reads this memory (12-bit pc in, 19-bit instruction out).
- Accepts a byte stream (valid/ready) carrying a framed program image. Packs bytes into 19-bit instruction words and writes them sequentially into instruction memory.
- Holds the CPU stalled while loading and reports done or error.
- Sits between the host/UART byte source and the instruction memory write port.

---
 rtl/instr_mem_loader_pkg.sv | 7 +
 rtl/instr_mem_loader_word_packer.sv | 40 ++++
 rtl/instr_mem_loader.sv | 83 ++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared loader states and widths
package instr_mem_loader_pkg;
  localparam int ADDR_W = 12;
  localparam int INSTR_W = 19;
  localparam logic [7:0] RESERVED_MASK = 8'hF8;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// word_packer: packs 3-byte little-endian groups (byte, accept in) into 19-bit words (word_valid, word, reserved_bad out)
module word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [7:0]         data,
  input  logic               accept,
  output logic               phase_end,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word,
  output logic               reserved_bad
);
  logic [1:0] phase;
  logic [7:0] b0, b1;
  assign phase_end = phase == 2'd2;
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      b0 <= '0;
      b1 <= '0;
      word <= '0;
      word_valid <= 1'b0;
      reserved_bad <= 1'b0;
    end else begin
      word_valid <= accept && phase_end;
      if (clr) phase <= '0;
      else if (accept) begin
        phase <= phase_end ? 2'd0 : phase + 2'd1;
        if (phase == 2'd0) b0 <= data;
        if (phase == 2'd1) b1 <= data;
        if (phase_end) begin
          word <= {data[2:0], b1, b0};
          reserved_bad <= |(data & RESERVED_MASK);
        end
      end
    end
  end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a framed byte stream into instruction memory, holding the cpu and reporting done/error
module instr_mem_loader #(
  parameter int ADDR_W = 12,
  parameter int INSTR_W = 19,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error
);
  import instr_mem_loader_pkg::*;
  state_t state, state_nx;
  logic xfer, go, phase_end, reserved_bad, bad_word, bad_now, last_word;
  logic [11:0] cnt, wcnt;
  logic [7:0] csum;
  assign xfer = in_valid && in_ready;
  assign go = start && (state == IDLE || state == DONE || state == ERR);
  assign last_word = wcnt == cnt - 12'd1;
  assign bad_now = bad_word || (imem_we && reserved_bad);
  word_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .data(in_data),
    .accept(xfer && state == DATA),
    .phase_end(phase_end),
    .word_valid(imem_we),
    .word(imem_wdata),
    .reserved_bad(reserved_bad)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, ERR: state_nx = go ? HDR0 : state;
      HDR0: state_nx = xfer ? HDR1 : HDR0;
      HDR1: state_nx = !xfer ? HDR1 : ({in_data[3:0], cnt[7:0]} != 12'd0) ? DATA : CSUM;
      DATA: state_nx = (xfer && phase_end && last_word) ? CSUM : DATA;
      CSUM: state_nx = !xfer ? CSUM : (in_data == csum && !bad_now) ? DONE : ERR;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == HDR0 || state == HDR1 || state == DATA || state == CSUM;
    cpu_hold = in_ready || imem_we;
    done = state == DONE;
    error = state == ERR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wcnt <= '0;
      csum <= '0;
      bad_word <= 1'b0;
      imem_addr <= '0;
    end else if (go) begin
      cnt <= '0;
      wcnt <= '0;
      csum <= '0;
      bad_word <= 1'b0;
      imem_addr <= BASE_ADDR;
    end else begin
      if (xfer && state != CSUM) csum <= csum ^ in_data;
      if (xfer && state == HDR0) cnt[7:0] <= in_data;
      if (xfer && state == HDR1) cnt[11:8] <= in_data[3:0];
      if (xfer && state == DATA && phase_end) wcnt <= wcnt + 12'd1;
      if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
      if (imem_we && reserved_bad) bad_word <= 1'b1;
    end
  end
endmodule
